// File: rtl/seg_scan_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl_if
//  Purpose  : Display-side signal bundle between the scan controller and the
//             digit mux / seven-segment driver.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_ctrl_if #(
   parameter int NUM_DIGITS = 5
);
   logic                  en;
   logic [3:0]            digit_in;
   logic [2:0]            seg_mux_sel;
   logic [NUM_DIGITS-1:0] an;
   logic [6:0]            seg;
   logic                  frame_done;

   modport master (
      input  en,
      input  digit_in,
      output seg_mux_sel,
      output an,
      output seg,
      output frame_done
   );

   modport slave (
      output en,
      output digit_in,
      input  seg_mux_sel,
      input  an,
      input  seg,
      input  frame_done
   );
endinterface
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_ctrl
//  Purpose  : Time-multiplexed seven-segment scan controller with a blanking
//             gap before each digit. Define SEG_LZB_EN for leading-zero blanking.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_ctrl #(
   parameter int NUM_DIGITS = 5,
   parameter int SCAN_DIV   = 50000,
   parameter int BLANK_CYC  = 16
) (
   input  logic            clk,
   input  logic            rst_n,
   seg_scan_ctrl_if.master bus
);

   localparam int                 c_max_cyc    = (SCAN_DIV > BLANK_CYC) ? SCAN_DIV : BLANK_CYC;
   localparam int                 c_cnt_w      = $clog2(c_max_cyc + 1);
   localparam logic [c_cnt_w-1:0] c_blank_last = c_cnt_w'(BLANK_CYC - 1);
   localparam logic [c_cnt_w-1:0] c_show_last  = c_cnt_w'(SCAN_DIV - 1);
   localparam logic [2:0]         c_top_idx    = 3'(NUM_DIGITS - 1);
   localparam logic [6:0]         c_seg_off    = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BLANK = 2'd1,
      ST_SHOW  = 2'd2
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic [c_cnt_w-1:0]    r_cnt;
   logic [c_cnt_w-1:0]    w_cnt_nxt;
   logic [2:0]            r_idx;
   logic [2:0]            w_idx_nxt;
   logic [NUM_DIGITS-1:0] r_an;
   logic [NUM_DIGITS-1:0] w_an_nxt;
   logic [6:0]            r_seg;
   logic [6:0]            w_seg_nxt;
   logic [6:0]            w_code_seg;
   logic                  r_frame_done;
   logic                  w_frame_done_nxt;
`ifdef SEG_LZB_EN
   logic                  r_lzb;
   logic                  w_lzb_nxt;
`endif

   // Active-low {g,f,e,d,c,b,a}; codes above 4'hA are dark.
   function automatic logic [6:0] f_decode(input logic [3:0] code);
      logic [6:0] v;
      case (code)
         4'h0:    v = 7'h40;
         4'h1:    v = 7'h79;
         4'h2:    v = 7'h24;
         4'h3:    v = 7'h30;
         4'h4:    v = 7'h19;
         4'h5:    v = 7'h12;
         4'h6:    v = 7'h02;
         4'h7:    v = 7'h78;
         4'h8:    v = 7'h00;
         4'h9:    v = 7'h10;
         4'hA:    v = 7'h3F;
         default: v = 7'h7F;
      endcase
      return v;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt      = r_state;
      w_cnt_nxt        = r_cnt + c_cnt_w'(1);
      w_idx_nxt        = r_idx;
      w_seg_nxt        = r_seg;
      w_frame_done_nxt = 1'b0;
      w_code_seg       = f_decode(bus.digit_in);
`ifdef SEG_LZB_EN
      w_lzb_nxt        = r_lzb;
      // The least significant digit always shows, so a value of zero reads "0".
      if (r_lzb && (bus.digit_in == 4'h0) && (r_idx != 3'd0)) begin
         w_code_seg = c_seg_off;
      end
`endif

      if (!bus.en) begin
         w_state_nxt = ST_IDLE;
         w_cnt_nxt   = '0;
         w_idx_nxt   = 3'd0;
         w_seg_nxt   = c_seg_off;
`ifdef SEG_LZB_EN
         w_lzb_nxt   = 1'b0;
`endif
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_state_nxt = ST_BLANK;
               w_cnt_nxt   = '0;
               w_idx_nxt   = c_top_idx;
`ifdef SEG_LZB_EN
               w_lzb_nxt   = 1'b1;
`endif
            end
            ST_BLANK: begin
               // The mux has settled for the whole gap; latch its decode now.
               if (r_cnt == c_blank_last) begin
                  w_state_nxt = ST_SHOW;
                  w_cnt_nxt   = '0;
                  w_seg_nxt   = w_code_seg;
`ifdef SEG_LZB_EN
                  if (bus.digit_in != 4'h0) begin
                     w_lzb_nxt = 1'b0;
                  end
`endif
               end
            end
            ST_SHOW: begin
               if (r_cnt == c_show_last) begin
                  w_state_nxt = ST_BLANK;
                  w_cnt_nxt   = '0;
                  if (r_idx == 3'd0) begin
                     w_idx_nxt        = c_top_idx;
                     w_frame_done_nxt = 1'b1;
`ifdef SEG_LZB_EN
                     w_lzb_nxt        = 1'b1;
`endif
                  end else begin
                     w_idx_nxt = r_idx - 3'd1;
                  end
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = '0;
               w_idx_nxt   = 3'd0;
               w_seg_nxt   = c_seg_off;
            end
         endcase
      end

      // Anodes are registered from the next state so they align with it.
      for (int i = 0; i < NUM_DIGITS; i++) begin
         w_an_nxt[i] = !((w_state_nxt == ST_SHOW) && (w_idx_nxt == 3'(i)));
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt        <= '0;
         r_idx        <= 3'd0;
         r_an         <= '1;
         r_seg        <= c_seg_off;
         r_frame_done <= 1'b0;
`ifdef SEG_LZB_EN
         r_lzb        <= 1'b0;
`endif
      end else begin
         r_cnt        <= w_cnt_nxt;
         r_idx        <= w_idx_nxt;
         r_an         <= w_an_nxt;
         r_seg        <= w_seg_nxt;
         r_frame_done <= w_frame_done_nxt;
`ifdef SEG_LZB_EN
         r_lzb        <= w_lzb_nxt;
`endif
      end
   end

   assign bus.seg_mux_sel = r_idx;
   assign bus.an          = r_an;
   assign bus.seg         = r_seg;
   assign bus.frame_done  = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_ctrl
//  Purpose  : Directed bench for seg_scan_ctrl (NUM_DIGITS=5, SCAN_DIV=4,
//             BLANK_CYC=2) with a combinational digit-mux model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_ctrl;

   logic clk;
   logic rst_n;
   int   n_checks = 0;
   int   n_fail   = 0;
   int   cyc      = 0;
   int   base     = 0;
   logic mon_on   = 1'b0;
   logic [2:0] last_sel = 3'd0;
   int   fd_q[$];
   int   sel_q[$];
   logic [3:0] mux_val [8];

   typedef struct {
      int         adv;
      logic [2:0] sel;
      logic [4:0] an;
      logic [6:0] seg;
      logic       fd;
   } vec_t;

   vec_t       tbl [14];
   logic [6:0] lzb_exp [5];

   seg_scan_ctrl_if #(.NUM_DIGITS(5)) bus ();

   seg_scan_ctrl #(
      .NUM_DIGITS(5),
      .SCAN_DIV  (4),
      .BLANK_CYC (2)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always_comb bus.digit_in = mux_val[bus.seg_mux_sel];

   always @(negedge clk) begin
      if (mon_on) begin
         if (bus.frame_done) fd_q.push_back(cyc - base);
         if (bus.seg_mux_sel != last_sel) begin
            sel_q.push_back(int'(bus.seg_mux_sel));
            last_sel = bus.seg_mux_sel;
         end
      end
   end

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic chk_all(input string name, input logic [2:0] sel, input logic [4:0] an,
                          input logic [6:0] seg, input logic fd);
      chk({name, ".sel"}, 32'(bus.seg_mux_sel), 32'(sel));
      chk({name, ".an"},  32'(bus.an),          32'(an));
      chk({name, ".seg"}, 32'(bus.seg),         32'(seg));
      chk({name, ".fd"},  32'(bus.frame_done),  32'(fd));
   endtask

   // From IDLE at a negedge: raise en; the next posedge is relative cycle 1.
   task automatic start_scan();
      bus.en = 1'b1;
      base   = cyc;
   endtask

   initial begin
      int fd_mark;
      logic found;

      tbl[0]  = '{1, 3'd4, 5'h1F, 7'h7F, 1'b0};
      tbl[1]  = '{1, 3'd4, 5'h1F, 7'h7F, 1'b0};
      tbl[2]  = '{1, 3'd4, 5'h0F, 7'h79, 1'b0};
      tbl[3]  = '{3, 3'd4, 5'h0F, 7'h79, 1'b0};
      tbl[4]  = '{1, 3'd3, 5'h1F, 7'h79, 1'b0};
      tbl[5]  = '{1, 3'd3, 5'h1F, 7'h79, 1'b0};
      tbl[6]  = '{1, 3'd3, 5'h17, 7'h24, 1'b0};
      tbl[7]  = '{6, 3'd2, 5'h1B, 7'h30, 1'b0};
      tbl[8]  = '{6, 3'd1, 5'h1D, 7'h19, 1'b0};
      tbl[9]  = '{6, 3'd0, 5'h1E, 7'h12, 1'b0};
      tbl[10] = '{3, 3'd0, 5'h1E, 7'h12, 1'b0};
      tbl[11] = '{1, 3'd4, 5'h1F, 7'h12, 1'b1};
      tbl[12] = '{1, 3'd4, 5'h1F, 7'h12, 1'b0};
      tbl[13] = '{1, 3'd4, 5'h0F, 7'h79, 1'b0};

`ifdef SEG_LZB_EN
      lzb_exp = '{7'h7F, 7'h7F, 7'h3F, 7'h78, 7'h40};
`else
      lzb_exp = '{7'h40, 7'h40, 7'h3F, 7'h78, 7'h40};
`endif

      for (int i = 0; i < 8; i++) mux_val[i] = 4'h0;
      for (int i = 0; i < 5; i++) mux_val[i] = 4'(5 - i);
      rst_n  = 1'b0;
      bus.en = 1'b0;

      // Reset state, then 20 cycles with en low.
      step(2);
      chk_all("reset", 3'd0, 5'h1F, 7'h7F, 1'b0);
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step(1);
         chk_all("idle", 3'd0, 5'h1F, 7'h7F, 1'b0);
      end

      // First frame, cycle by cycle.
      start_scan();
      mon_on = 1'b1;
      for (int i = 0; i < 14; i++) begin
         step(tbl[i].adv);
         chk_all($sformatf("vec%0d", i), tbl[i].sel, tbl[i].an, tbl[i].seg, tbl[i].fd);
      end

      // Two full frames: pulses at relative cycles 31 and 61.
      step(32);
      chk("fd_count", 32'(fd_q.size()), 32'd2);
      if (fd_q.size() >= 2) begin
         chk("fd_first",  32'(fd_q[0]), 32'd31);
         chk("fd_second", 32'(fd_q[1]), 32'd61);
      end
      chk("sel_count_ge6", 32'(sel_q.size() >= 6), 32'd1);
      if (sel_q.size() >= 6) begin
         chk("sel_seq0", 32'(sel_q[0]), 32'd4);
         chk("sel_seq1", 32'(sel_q[1]), 32'd3);
         chk("sel_seq2", 32'(sel_q[2]), 32'd2);
         chk("sel_seq3", 32'(sel_q[3]), 32'd1);
         chk("sel_seq4", 32'(sel_q[4]), 32'd0);
         chk("sel_seq5", 32'(sel_q[5]), 32'd4);
      end

      // Drop en while idx 2 is lit.
      found = 1'b0;
      for (int i = 0; i < 100 && !found; i++) begin
         step(1);
         if (bus.seg_mux_sel == 3'd2 && bus.an == 5'h1B) found = 1'b1;
      end
      chk("wait_idx2_show", 32'(found), 32'd1);
      fd_mark = fd_q.size();
      bus.en  = 1'b0;
      step(1);
      chk_all("en_drop", 3'd0, 5'h1F, 7'h7F, 1'b0);
      step(1);
      chk_all("en_drop_hold", 3'd0, 5'h1F, 7'h7F, 1'b0);
      start_scan();
      step(1);
      chk_all("reen_blank", 3'd4, 5'h1F, 7'h7F, 1'b0);
      step(2);
      chk_all("reen_show", 3'd4, 5'h0F, 7'h79, 1'b0);
      chk("reen_no_fd", 32'(fd_q.size()), 32'(fd_mark));

      // Digits 0,0,A,7,0 (idx 4..0), with a mid-SHOW input change on idx 1.
      bus.en = 1'b0;
      step(1);
      mux_val[4] = 4'h0; mux_val[3] = 4'h0; mux_val[2] = 4'hA;
      mux_val[1] = 4'h7; mux_val[0] = 4'h0;
      start_scan();
      step(3);
      chk_all("lz_d4", 3'd4, 5'h0F, lzb_exp[0], 1'b0);
      step(6);
      chk_all("lz_d3", 3'd3, 5'h17, lzb_exp[1], 1'b0);
      step(6);
      chk_all("lz_d2", 3'd2, 5'h1B, lzb_exp[2], 1'b0);
      step(6);
      chk_all("lz_d1", 3'd1, 5'h1D, lzb_exp[3], 1'b0);
      mux_val[1] = 4'h9;
      step(1);
      chk("show_hold_seg", 32'(bus.seg), 32'h78);
      mux_val[1] = 4'h7;
      step(5);
      chk_all("lz_d0", 3'd0, 5'h1E, lzb_exp[4], 1'b0);
      step(6);
      chk_all("lz_d4_frame2", 3'd4, 5'h0F, lzb_exp[0], 1'b0);

      // Codes B..F are dark; then an asynchronous reset between edges.
      bus.en = 1'b0;
      step(1);
      for (int i = 0; i < 5; i++) mux_val[i] = 4'(4'hB + i);
      start_scan();
      for (int k = 0; k < 5; k++) begin
         step((k == 0) ? 3 : 6);
         chk_all($sformatf("blank_code%0d", k), 3'(4 - k), ~(5'b1 << (4 - k)), 7'h7F, 1'b0);
      end
      step(6);
      chk_all("pre_reset", 3'd4, 5'h0F, 7'h7F, 1'b0);
      #2 rst_n = 1'b0;
      #1;
      chk_all("async_reset", 3'd0, 5'h1F, 7'h7F, 1'b0);
      step(1);
      rst_n = 1'b1;
      step(1);
      chk_all("post_reset_blank", 3'd4, 5'h1F, 7'h7F, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
